// File: rtl/hash_line_enumerator.sv
// Scans a range of cache-line indices and emits the address of every line
// whose 4-bit hash selects the target vcache x-subcoord.
module hash_line_enumerator #(
    parameter int data_width_p      = 32,
    parameter int x_subcord_width_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [x_subcord_width_p-1:0] my_x_i,
    input  logic                         start_v_i,
    input  logic [19:0]                  start_line_i,
    input  logic [20:0]                  count_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [data_width_p-1:0]     eva_o,
    input  logic                         yumi_i,
    output logic                         done_o,
    output logic [20:0]                  match_count_o
);

    localparam logic [19:0] row0 = 20'b11010001111010000010;
    localparam logic [19:0] row1 = 20'b00100101111101011110;
    localparam logic [19:0] row2 = 20'b01111011100010100001;
    localparam logic [19:0] row3 = 20'b01000010000000100110;

    function automatic logic [3:0] line_hash(input logic [19:0] l);
        line_hash = {^(row3 & l), ^(row2 & l), ^(row1 & l), ^(row0 & l)};
    endfunction

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                       state;
    logic [19:0]                  cursor;
    logic [20:0]                  remaining;
    logic [x_subcord_width_p-1:0] target;

    // The output slot can take a new line when empty or being consumed.
    logic free;
    logic hit;
    assign free = !v_o || yumi_i;
    assign hit  = (line_hash(cursor) == target);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= IDLE;
            ready_o       <= 1'b1;
            v_o           <= 1'b0;
            done_o        <= 1'b0;
            eva_o         <= '0;
            match_count_o <= '0;
            cursor        <= '0;
            remaining     <= '0;
            target        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_v_i) begin
                        cursor        <= start_line_i;
                        remaining     <= count_i;
                        target        <= my_x_i;
                        match_count_o <= '0;
                        ready_o       <= 1'b0;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (free) begin
                        if (remaining != '0) begin
                            cursor    <= cursor + 20'd1;
                            remaining <= remaining - 21'd1;
                            if (hit) begin
                                eva_o <= {{(data_width_p-26){1'b0}},
                                          cursor, 6'b0};
                                v_o   <= 1'b1;
                                match_count_o <= match_count_o + 21'd1;
                            end else begin
                                v_o <= 1'b0;
                            end
                        end else begin
                            v_o    <= 1'b0;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    v_o     <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_line_enumerator.sv
// Randomized and directed checks of hash_line_enumerator against a
// bit-level reference of the line hash and a list of expected addresses.
module tb_hash_line_enumerator;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [3:0]  my_x_i;
    logic        start_v_i;
    logic [19:0] start_line_i;
    logic [20:0] count_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] eva_o;
    logic        yumi_i;
    logic        done_o;
    logic [20:0] match_count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    hash_line_enumerator #(
        .data_width_p(32),
        .x_subcord_width_p(4)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .my_x_i(my_x_i),
        .start_v_i(start_v_i),
        .start_line_i(start_line_i),
        .count_i(count_i),
        .ready_o(ready_o),
        .v_o(v_o),
        .eva_o(eva_o),
        .yumi_i(yumi_i),
        .done_o(done_o),
        .match_count_o(match_count_o)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int unsigned rows [4] = '{32'hD1E82, 32'h25F5E, 32'h7B8A1, 32'h42026};

    function automatic int unsigned ref_hash(input int unsigned l);
        int unsigned h = 0;
        for (int i = 0; i < 4; i++) begin
            int unsigned p = 0;
            for (int b = 0; b < 20; b++)
                if (((rows[i] >> b) & 1) == 1 && ((l >> b) & 1) == 1)
                    p = p ^ 1;
            h = h | (p << i);
        end
        return h;
    endfunction

    // mode 0: always consume, 1: random consume, 2: hold first output 10 cycles
    task automatic run_scan(input int unsigned x, input int unsigned start,
                            input int unsigned cnt, input int mode);
        logic [31:0] got[$];
        logic [31:0] expq[$];
        logic [31:0] held;
        int k, done_k, errs, hold, stall_err, bound;
        logic y;
        held = '0;
        @(negedge clk_i);
        chk("ready_idle", ready_o, 1);
        my_x_i       = x[3:0];
        start_line_i = start[19:0];
        count_i      = cnt[20:0];
        start_v_i    = 1'b1;
        @(negedge clk_i);
        start_v_i = 1'b0;
        chk("ready_busy", ready_o, 0);
        k = 1;
        done_k = 0;
        hold = (mode == 2) ? 10 : 0;
        stall_err = 0;
        bound = int'(cnt) * 3 + 50;
        while (done_k == 0 && k <= bound) begin
            if (done_o) begin
                done_k = k;
                if (v_o) stall_err++;
            end else begin
                y = 1'b0;
                if (hold > 0 && (v_o || hold < 10)) begin
                    if (hold < 10 && (!v_o || eva_o != held)) stall_err++;
                    held = eva_o;
                    hold--;
                end else if (v_o) begin
                    y = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                yumi_i = y;
                if (v_o && y) got.push_back(eva_o);
                @(negedge clk_i);
                k++;
            end
        end
        yumi_i = 1'b0;
        chk("done_seen", done_k != 0, 1);
        if (cnt == 0) chk("done_lat", done_k, 2);
        if (mode == 2) chk("stall_hold", stall_err + hold, 0);
        else chk("v_in_done", stall_err, 0);
        for (int unsigned j = 0; j < cnt; j++) begin
            int unsigned l = (start + j) % 32'h100000;
            if (ref_hash(l) == x) expq.push_back(32'(l * 64));
        end
        errs = 0;
        if (got.size() == expq.size()) begin
            foreach (got[i]) if (got[i] != expq[i]) errs++;
        end else begin
            errs = -1;
        end
        chk("n_emit", got.size(), expq.size());
        chk("lines", errs, 0);
        if (got.size() > 0) chk("first_eva", got[0], expq.size() > 0 ? expq[0] : 0);
        chk("match_cnt", match_count_o, got.size());
        @(negedge clk_i);
        chk("mc_hold", match_count_o, expq.size());
        chk("ready_back", ready_o, 1);
    endtask

    initial begin
        reset_i = 1'b1;
        my_x_i = '0;
        start_v_i = 1'b0;
        start_line_i = '0;
        count_i = '0;
        yumi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        chk("rst_ready", ready_o, 1);
        chk("rst_v", v_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_eva", eva_o, 0);
        chk("rst_mc", match_count_o, 0);

        run_scan(0, 0, 4, 0);
        run_scan(4, 0, 4, 0);
        run_scan(15, 0, 4, 0);
        run_scan(11, 0, 4, 0);
        chk("hash_fffff", ref_hash(32'hFFFFF), 9);
        run_scan(0, 32'hFFFFF, 2, 0);
        run_scan(0, 0, 4, 2);
        run_scan(3, 0, 0, 0);

        // abandon a scan with reset
        @(negedge clk_i);
        my_x_i = 4'd0;
        start_line_i = 20'd0;
        count_i = 21'd200;
        start_v_i = 1'b1;
        @(negedge clk_i);
        start_v_i = 1'b0;
        yumi_i = 1'b1;
        repeat (20) @(negedge clk_i);
        reset_i = 1'b1;
        yumi_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_v", v_o, 0);
        chk("mid_rst_mc", match_count_o, 0);
        begin
            int seen = 0;
            repeat (5) begin
                if (done_o) seen++;
                @(negedge clk_i);
            end
            chk("mid_rst_nodone", seen, 0);
        end

        run_scan($urandom_range(0, 15), 32'hFC000 + $urandom_range(0, 4000),
                 12000, 1);
        run_scan($urandom_range(0, 15), $urandom_range(0, 32'hFFFFF),
                 12000, 1);
        run_scan($urandom_range(0, 15), $urandom_range(0, 32'hFFFFF),
                 $urandom_range(1, 300), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
